guess_grader: RTL and testbench

- Consumer of the 12-bit masterPattern built during the load phase; sits directly downstream of the master-pattern builder.
- Each accepted guess of four 3-bit shapes is graded against the master pattern over a fixed 8-cycle sequence.
- Reports Znarly (right shape, right slot) and Zood (right shape, wrong slot).
- Tracks the round count, win and game-over state for the game controller.

---
 rtl/guess_grader.sv | 138 +++++++++++++
 tb/tb_guess_grader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_grader.sv
// Grades a four-slot shape guess against the loaded master pattern over a fixed
// 8-cycle sequence, reporting exact (Znarly) and wrong-slot (Zood) matches plus game state.
module guess_grader #(
  parameter int MAX_ROUNDS = 8,
  parameter int NUM_SHAPES = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] masterPattern,
  input  logic        LoadDone,
  input  logic        NewGame,
  input  logic [11:0] Guess,
  input  logic        GradeIt,
  output logic        Busy,
  output logic        GradeDone,
  output logic [2:0]  Znarly,
  output logic [2:0]  Zood,
  output logic        BadGuess,
  output logic [3:0]  RoundNumber,
  output logic        GameWon,
  output logic        GameOver
);

  localparam logic [2:0] LAST_SHAPE = 3'(NUM_SHAPES);
  localparam logic [3:0] ROUND_MAX  = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXACT, COUNT, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] guess_q, master_q;
  logic [2:0]  exact_q, acc_q, shape_q;
  logic        accept_req, guess_bad;

  function automatic logic [2:0] count_shape(input logic [11:0] pat, input logic [2:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < 4; k++)
      if (pat[3*k +: 3] == s) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [2:0] count_exact(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] n;
    n = 3'd0;
    for (int k = 0; k < 4; k++)
      if (a[3*k +: 3] == b[3*k +: 3]) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic has_bad_shape(input logic [11:0] pat);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++)
      if (pat[3*k +: 3] == 3'd0 || pat[3*k +: 3] > LAST_SHAPE) bad = 1'b1;
    return bad;
  endfunction

  assign accept_req = (state == IDLE) && GradeIt && LoadDone && !GameOver && !NewGame;
  assign guess_bad  = has_bad_shape(Guess);
  assign Busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_req && !guess_bad) state_nxt = EXACT;
      EXACT:   state_nxt = COUNT;
      COUNT:   if (shape_q == LAST_SHAPE) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (NewGame) state_nxt = IDLE;
  end

  // Working registers: latched operands, exact count, and per-shape match accumulator
  always_ff @(posedge clock) begin
    if (accept_req && !guess_bad) begin
      guess_q  <= Guess;
      master_q <= masterPattern;
    end
    if (state == EXACT) begin
      exact_q <= count_exact(guess_q, master_q);
      shape_q <= 3'd1;
      acc_q   <= 3'd0;
    end else if (state == COUNT) begin
      acc_q   <= acc_q + min3(count_shape(guess_q, shape_q), count_shape(master_q, shape_q));
      shape_q <= shape_q + 3'd1;
    end
  end

  // Reported results and game state
  always_ff @(posedge clock) begin
    if (reset) begin
      GradeDone   <= 1'b0;
      Znarly      <= 3'd0;
      Zood        <= 3'd0;
      BadGuess    <= 1'b0;
      RoundNumber <= 4'd0;
      GameWon     <= 1'b0;
      GameOver    <= 1'b0;
    end else begin
      GradeDone <= 1'b0;
      if (NewGame) begin
        Znarly      <= 3'd0;
        Zood        <= 3'd0;
        BadGuess    <= 1'b0;
        RoundNumber <= 4'd0;
        GameWon     <= 1'b0;
        GameOver    <= 1'b0;
      end else if (accept_req && guess_bad) begin
        BadGuess  <= 1'b1;
        GradeDone <= 1'b1;
      end else if (accept_req) begin
        BadGuess <= 1'b0;
      end else if (state == DONE) begin
        Znarly    <= exact_q;
        Zood      <= acc_q - exact_q;
        GradeDone <= 1'b1;
        if (RoundNumber < ROUND_MAX) RoundNumber <= RoundNumber + 4'd1;
        if (exact_q == 3'd4) begin
          GameWon  <= 1'b1;
          GameOver <= 1'b1;
        end else if (RoundNumber + 4'd1 >= ROUND_MAX) begin
          GameOver <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_guess_grader.sv
// Directed bench for guess_grader: table of graded guesses plus hand sequences for
// invalid guesses, gating, round limit and aborts.
module tb_guess_grader;

  logic        clock = 1'b0;
  logic        reset, LoadDone, NewGame, GradeIt;
  logic [11:0] masterPattern, Guess;
  logic        Busy, GradeDone, BadGuess, GameWon, GameOver;
  logic [2:0]  Znarly, Zood;
  logic [3:0]  RoundNumber;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] MASTER = 12'b001_010_101_110;

  guess_grader #(.MAX_ROUNDS(8), .NUM_SHAPES(6)) dut (
    .clock(clock), .reset(reset), .masterPattern(masterPattern), .LoadDone(LoadDone),
    .NewGame(NewGame), .Guess(Guess), .GradeIt(GradeIt), .Busy(Busy),
    .GradeDone(GradeDone), .Znarly(Znarly), .Zood(Zood), .BadGuess(BadGuess),
    .RoundNumber(RoundNumber), .GameWon(GameWon), .GameOver(GameOver)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] guess;
    logic [2:0]  znarly;
    logic [2:0]  zood;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({Busy, GradeDone, Znarly, Zood, BadGuess, RoundNumber, GameWon, GameOver}), 0);
  endtask

  task automatic new_game();
    NewGame = 1'b1;
    step();
    NewGame = 1'b0;
  endtask

  // Pulse GradeIt and return cycles from accept edge to GradeDone (-1 if none within bound)
  task automatic run_grade(input logic [11:0] g, output int lat);
    Guess   = g;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (GradeDone) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic no_done(input int n, input string name);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (GradeDone) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  initial begin
    int lat, pulses;
    int exp_won;

    vecs[0] = '{12'b001_010_101_110, 3'd4, 3'd0};
    vecs[1] = '{12'b110_101_010_001, 3'd0, 3'd4};
    vecs[2] = '{12'b001_001_001_001, 3'd1, 3'd0};
    vecs[3] = '{12'b010_010_010_010, 3'd1, 3'd0};
    vecs[4] = '{12'b010_001_101_110, 3'd2, 3'd2};
    vecs[5] = '{12'b011_100_011_100, 3'd0, 3'd0};

    reset = 1'b1; LoadDone = 1'b0; NewGame = 1'b0; GradeIt = 1'b0;
    masterPattern = MASTER; Guess = 12'd0;
    step(); step();
    reset = 1'b0;
    chk_zero("reset_state");
    LoadDone = 1'b1;

    for (int v = 0; v < 6; v++) begin
      new_game();
      run_grade(vecs[v].guess, lat);
      exp_won = (vecs[v].znarly == 3'd4) ? 1 : 0;
      chk($sformatf("latency_v%0d", v), lat, 8);
      chk($sformatf("znarly_v%0d", v), int'(Znarly), int'(vecs[v].znarly));
      chk($sformatf("zood_v%0d", v), int'(Zood), int'(vecs[v].zood));
      chk($sformatf("round_v%0d", v), int'(RoundNumber), 1);
      chk($sformatf("won_v%0d", v), int'(GameWon), exp_won);
      chk($sformatf("over_v%0d", v), int'(GameOver), exp_won);
      step();
      chk($sformatf("done_pulse_v%0d", v), int'(GradeDone), 0);
      if (v == 0) begin
        GradeIt = 1'b1;
        step();
        GradeIt = 1'b0;
        chk("won_ignore_busy", int'(Busy), 0);
        no_done(12, "won_ignore_done");
        chk("won_ignore_round", int'(RoundNumber), 1);
      end
    end

    // Invalid guess keeps earlier results and issues an immediate GradeDone
    new_game();
    run_grade(vecs[1].guess, lat);
    step();
    Guess = 12'b001_000_101_110;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    chk("bad_done", int'(GradeDone), 1);
    chk("bad_flag", int'(BadGuess), 1);
    chk("bad_busy", int'(Busy), 0);
    chk("bad_round", int'(RoundNumber), 1);
    chk("bad_zood_hold", int'(Zood), 4);
    step();
    chk("bad_done_clear", int'(GradeDone), 0);
    Guess = vecs[2].guess;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    chk("valid_clears_bad", int'(BadGuess), 0);
    chk("valid_busy", int'(Busy), 1);
    for (int i = 0; i < 9; i++) step();

    // LoadDone low refuses grading
    LoadDone = 1'b0;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    chk("noload_busy", int'(Busy), 0);
    no_done(12, "noload_done");
    LoadDone = 1'b1;

    // GradeIt held through Busy starts exactly one grade
    new_game();
    pulses = 0;
    Guess = vecs[3].guess;
    GradeIt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 4) GradeIt = 1'b0;
      if (GradeDone) pulses++;
    end
    chk("held_pulses", pulses, 1);
    chk("held_round", int'(RoundNumber), 1);

    // Round limit
    new_game();
    for (int r = 0; r < 8; r++) begin
      run_grade(12'b010_010_010_010, lat);
      chk($sformatf("limit_lat_r%0d", r), lat, 8);
      step();
    end
    chk("limit_round", int'(RoundNumber), 8);
    chk("limit_over", int'(GameOver), 1);
    chk("limit_won", int'(GameWon), 0);
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    chk("limit_ignore_busy", int'(Busy), 0);
    no_done(12, "limit_ignore_done");
    chk("limit_round_hold", int'(RoundNumber), 8);
    new_game();
    chk_zero("newgame_clear");

    // NewGame three edges after accept
    run_grade(vecs[1].guess, lat);
    step();
    Guess = vecs[4].guess;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    step(); step();
    NewGame = 1'b1;
    step();
    NewGame = 1'b0;
    chk_zero("abort_newgame_state");
    no_done(12, "abort_newgame_done");

    // Reset five edges after accept
    run_grade(vecs[1].guess, lat);
    step();
    Guess = vecs[4].guess;
    GradeIt = 1'b1;
    step();
    GradeIt = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("abort_reset_state");
    no_done(12, "abort_reset_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
